// File: rtl/instr_decode_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : instr_decode_ctrl_if
// Brief  : Fetch-to-decoder handshake and decoded datapath control bundle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_decode_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] regEnable;
    logic [3:0]  a_select;
    logic [3:0]  b_select;
    logic        use_imm;
    logic [15:0] immediate;
    logic [7:0]  opCode;
    logic        busy;
    logic        done;

    modport master (
        output instr, instr_valid,
        input  instr_ready, regEnable, a_select, b_select, use_imm,
               immediate, opCode, busy, done
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, regEnable, a_select, b_select, use_imm,
               immediate, opCode, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/instr_decode_ctrl.sv
//------------------------------------------------------------------------------
// Module : instr_decode_ctrl
// Brief  : Instruction decoder/sequencer driving the register-file/ALU datapath.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_decode_ctrl #(
    parameter int         EXEC_CYCLES = 1,
    parameter logic [3:0] CMP_OP      = 4'b1011,
    parameter logic [3:0] LUI_OP      = 4'b1111
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instr_decode_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_load = 4'(EXEC_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_cmp;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_regen;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic        r_use_imm;
    logic [15:0] r_imm;
    logic [7:0]  r_opcode;

    logic        w_accept;
    logic [3:0]  w_op;
    logic [7:0]  w_opcode;
    logic        w_use_imm;
    logic [15:0] w_imm;
    logic        w_cmp;

    assign w_accept = (r_state == S_IDLE) && bus.instr_valid;
    assign w_op     = bus.instr[15:12];

    always_comb begin
        w_opcode  = {4'b0000, bus.instr[7:4]};
        w_use_imm = 1'b0;
        w_imm     = 16'h0000;
        w_cmp     = (bus.instr[7:4] == CMP_OP);
        if (w_op != 4'b0000) begin
            w_opcode  = {w_op, 4'b0000};
            w_use_imm = 1'b1;
            w_cmp     = (w_op == CMP_OP);
            // Logical ops zero-extend so masks like 0x80 are not smeared upward.
            if (w_op == 4'd1 || w_op == 4'd2 || w_op == 4'd3)
                w_imm = {8'h00, bus.instr[7:0]};
            else if (w_op == LUI_OP)
                w_imm = {bus.instr[7:0], 8'h00};
            else
                w_imm = {{8{bus.instr[7]}}, bus.instr[7:0]};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.instr_valid) w_next = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0)   w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_cmp     <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_regen   <= 16'h0000;
            r_a       <= 4'd0;
            r_b       <= 4'd0;
            r_use_imm <= 1'b0;
            r_imm     <= 16'h0000;
            r_opcode  <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt     <= c_cnt_load;
                r_cmp     <= w_cmp;
                r_a       <= bus.instr[11:8];
                r_b       <= bus.instr[3:0];
                r_use_imm <= w_use_imm;
                r_imm     <= w_imm;
                r_opcode  <= w_opcode;
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_regen <= (w_next == S_WRITE && !r_cmp) ? (16'h0001 << r_a) : 16'h0000;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_WRITE);
            r_ready <= (w_next == S_IDLE);
        end
    end

    assign bus.instr_ready = r_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.regEnable   = r_regen;
    assign bus.a_select    = r_a;
    assign bus.b_select    = r_b;
    assign bus.use_imm     = r_use_imm;
    assign bus.immediate   = r_imm;
    assign bus.opCode      = r_opcode;

endmodule

`default_nettype wire

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Control-side counterpart of the register-file/ALU datapath.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into regEnable, a_select, b_select, use_imm, immediate and opCode.
- Sequences each instruction through EXEC (operands held while the ALU settles) and WRITE (one-cycle one-hot register write).
- Sits between instruction fetch and the datapath; opCode feeds the ALU directly.

Parameters:
- EXEC_CYCLES, 1, cycles operands/opCode are held in EXEC before the WRITE cycle (1..15).
- CMP_OP, 4'b1011, opcode/ext value meaning compare (no register write).
- LUI_OP, 4'b1111, immediate opcode meaning load-upper (immediate shifted left 8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr  input  16  instruction word.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  decoder can accept an instruction (high only in IDLE).
- regEnable  output  16  one-hot register write enable, asserted only in WRITE.
- a_select  output  4  A-operand/destination register (instr[11:8]).
- b_select  output  4  B-operand register (instr[3:0]).
- use_imm  output  1  1 = ALU B input takes immediate.
- immediate  output  16  extended immediate.
- opCode  output  8  ALU opcode.
- busy  output  1  high in EXEC and WRITE.
- done  output  1  one-cycle pulse in the WRITE cycle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, exec counter=0. regEnable, a_select, b_select, use_imm, immediate, opCode, busy and done are all 0. instr_ready=1 once reset is released.
- States: IDLE, EXEC, WRITE.
- IDLE:
  - instr_ready=1, busy=0, regEnable=0.
  - Decode outputs hold the last instruction's values.
  - On a clock edge with instr_valid=1: register the decode outputs, load exec counter=EXEC_CYCLES-1, go to EXEC.
- EXEC:
  - instr_ready=0, busy=1, regEnable=0.
  - Decode outputs stable.
  - Counter decrements each cycle; at 0, go to WRITE.
  - Lasts exactly EXEC_CYCLES cycles.
- WRITE (exactly 1 cycle):
  - busy=1, done=1.
  - regEnable = 16'h0001 << instr[11:8], except compare, where regEnable=0.
  - Next state IDLE.
- Decode, register-register (instr[15:12]=0000):
  - opCode = {4'b0000, instr[7:4]}, use_imm=0, immediate=0.
  - Compare when instr[7:4]=CMP_OP.
- Decode, immediate (instr[15:12]!=0000):
  - opCode = {instr[15:12], 4'b0000}, use_imm=1, b_select=instr[3:0] (don't-care to datapath).
  - Compare when instr[15:12]=CMP_OP.
  - Immediate extension by op:
    - 0001/0010/0011 (logical): zero-extend instr[7:0].
    - LUI_OP: {instr[7:0], 8'h00}.
    - All others: sign-extend instr[7:0].
- Throughput: one instruction per EXEC_CYCLES+2 cycles. instr_valid outside IDLE is ignored and not buffered; the source holds instr until it sees instr_ready.
- Reset mid-EXEC/WRITE: abort immediately, no regEnable pulse, all outputs to reset values.
- All outputs are registered; no combinational path from instr to outputs.

Test Plan:
- ADD r3,r5 (instr=16'h0355, valid one cycle, EXEC_CYCLES=1):
  - Next cycle: a_select=3, b_select=5, use_imm=0, opCode=8'h05, busy=1, instr_ready=0.
  - Following cycle: regEnable=16'h0008, done=1.
  - Then IDLE, instr_ready=1.
- ADDI r2,#-3 (16'h52FD) -> immediate=16'hFFFD, use_imm=1, opCode=8'h50, regEnable=16'h0004 in WRITE.
- Immediate extensions:
  - ANDI r1,#0x80 (16'h1180) -> immediate=16'h0080.
  - LUI r4,#0x12 (16'hF412) -> immediate=16'h1200, opCode=8'hF0, regEnable=16'h0010.
- CMP r6,r7 (16'h06B7) and CMPI r6,#1 (16'hB601) -> done pulses, regEnable stays 16'h0000 throughout.
- EXEC_CYCLES=3, instr_valid held high with 16'h0355 then 16'h0AB1 -> second accepted only in the IDLE cycle after WRITE. Accept edges 5 cycles apart; busy high 4 cycles per instruction.
- Drive reset=0 during EXEC of 16'h0355 -> all outputs 0 immediately (asynchronous), no regEnable pulse. After release, instr_ready=1 and the next instruction decodes normally.
